// File: rtl/mips_pkg.sv
// mips_pkg -- definitions shared by the fetch stage.
//   fetch_state_e    : fetch FSM states (REQ, DROP, HOLD)
//   RESET_PC_DEFAULT : default PC after reset
//   NOP              : instruction word presented when nothing valid is fetched
//   word_align()     : clears the two byte-offset bits of an address
package mips_pkg;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,  // fetch outstanding, response will be kept
    ST_DROP = 2'd1,  // stale fetch outstanding, response will be discarded
    ST_HOLD = 2'd2   // instruction buffered and presented to decode
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP              = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/pc_next_mux.sv
// pc_next_mux -- next-PC selection for the fetch stage.
//   pc            in  : current fetch PC
//   branch        in  : branch taken in decode
//   branch_target in  : branch target
//   jump          in  : jump in decode
//   jump_target   in  : jump target
//   redirect      out : jump | branch
//   target        out : word-aligned redirect target (jump wins over branch)
//   pc_plus4      out : pc + 4, wrapping modulo 2^32
//   pc_next       out : target when redirecting, else pc_plus4
module pc_next_mux
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        branch,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        redirect,
  output logic [31:0] target,
  output logic [31:0] pc_plus4,
  output logic [31:0] pc_next
);

  assign redirect = jump | branch;
  assign target   = word_align(jump ? jump_target : branch_target);
  assign pc_plus4 = pc + 32'd4;
  assign pc_next  = redirect ? target : pc_plus4;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch stage with a request/ack memory port.
//   clk, rst_n             : clock, asynchronous active-low reset
//   StallF                 : 1 = hold fetch (redirect and consumption ignored)
//   PCSrcD, PCBranchD      : branch taken in decode and its target
//   JumpD, PCJumpD         : jump in decode and its target (priority over branch)
//   imem_req, imem_addr    : memory request, held until ack; address stable meanwhile
//   imem_ack, imem_rdata   : one-cycle completion pulse and its instruction word
//   PCF, PCPlus4F          : current fetch PC and PC+4
//   InstrF, BubbleF        : buffered instruction (NOP when invalid), 1 = no valid instruction
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        StallF,
  input  logic        PCSrcD,
  input  logic [31:0] PCBranchD,
  input  logic        JumpD,
  input  logic [31:0] PCJumpD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PCF,
  output logic [31:0] InstrF,
  output logic [31:0] PCPlus4F,
  output logic        BubbleF
);

  fetch_state_e state_reg;
  logic [31:0]  pc_reg;
  logic [31:0]  addr_reg;
  logic [31:0]  buf_reg;
  logic         valid_reg;
  logic         req_reg;

  logic         redirect;
  logic [31:0]  target;
  logic [31:0]  pc_plus4;
  logic [31:0]  pc_next;
  logic         take_redirect;

  pc_next_mux u_pc_next_mux (
    .pc            (pc_reg),
    .branch        (PCSrcD),
    .branch_target (PCBranchD),
    .jump          (JumpD),
    .jump_target   (PCJumpD),
    .redirect      (redirect),
    .target        (target),
    .pc_plus4      (pc_plus4),
    .pc_next       (pc_next)
  );

  // A stalled fetch stage must not lose a redirect it cannot act on yet;
  // decode holds the redirect until the stall clears.
  assign take_redirect = redirect & ~StallF;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_REQ;
      pc_reg    <= RESET_PC;
      addr_reg  <= RESET_PC;
      buf_reg   <= NOP;
      valid_reg <= 1'b0;
      req_reg   <= 1'b0;
    end else if (!req_reg && state_reg != ST_HOLD) begin
      // First cycle after reset release: raise the request, and ignore any
      // ack still in flight from a transaction the reset abandoned.
      req_reg <= 1'b1;
    end else begin
      case (state_reg)
        ST_REQ: begin
          if (imem_ack && take_redirect) begin
            // Response belongs to the wrong path; reissue at the target at once.
            pc_reg   <= target;
            addr_reg <= target;
          end else if (imem_ack) begin
            buf_reg   <= imem_rdata;
            valid_reg <= 1'b1;
            req_reg   <= 1'b0;
            state_reg <= ST_HOLD;
          end else if (take_redirect) begin
            // Address must stay stable until the pending ack arrives.
            pc_reg    <= target;
            state_reg <= ST_DROP;
          end
        end
        ST_DROP: begin
          if (imem_ack) begin
            pc_reg    <= take_redirect ? target : pc_reg;
            addr_reg  <= take_redirect ? target : pc_reg;
            state_reg <= ST_REQ;
          end else if (take_redirect) begin
            pc_reg <= target;
          end
        end
        ST_HOLD: begin
          if (!StallF) begin
            pc_reg    <= pc_next;
            addr_reg  <= pc_next;
            valid_reg <= 1'b0;
            req_reg   <= 1'b1;
            state_reg <= ST_REQ;
          end
        end
        default: begin
          state_reg <= ST_REQ;
          req_reg   <= 1'b1;
        end
      endcase
    end
  end

  assign imem_req  = req_reg;
  assign imem_addr = addr_reg;
  assign PCF       = pc_reg;
  assign PCPlus4F  = pc_plus4;
  assign BubbleF   = ~valid_reg;
  assign InstrF    = valid_reg ? buf_reg : NOP;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit -- directed self-checking bench for fetch_unit.
// The bench plays the instruction memory by hand, one cycle at a time.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        StallF;
  logic        PCSrcD;
  logic [31:0] PCBranchD;
  logic        JumpD;
  logic [31:0] PCJumpD;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] PCF;
  logic [31:0] InstrF;
  logic [31:0] PCPlus4F;
  logic        BubbleF;

  int tests = 0;
  int fails = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .StallF     (StallF),
    .PCSrcD     (PCSrcD),
    .PCBranchD  (PCBranchD),
    .JumpD      (JumpD),
    .PCJumpD    (PCJumpD),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .PCF        (PCF),
    .InstrF     (InstrF),
    .PCPlus4F   (PCPlus4F),
    .BubbleF    (BubbleF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n      = 1'b1;
    StallF     = 1'b0;
    PCSrcD     = 1'b0;
    PCBranchD  = 32'h0;
    JumpD      = 1'b0;
    PCJumpD    = 32'h0;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;

    // Reset state.
    #1 rst_n = 1'b0;
    #1;
    chk("rst_pcf",    PCF, 32'h0);
    chk("rst_addr",   imem_addr, 32'h0);
    chk("rst_req",    {31'b0, imem_req}, 32'h0);
    chk("rst_instr",  InstrF, 32'h0);
    chk("rst_bubble", {31'b0, BubbleF}, 32'h1);
    chk("rst_pc4",    PCPlus4F, 32'h4);

    // Release between edges; a late ack in the first cycle must be ignored.
    @(posedge clk);
    @(posedge clk);
    #7;
    rst_n      = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("rel_req_low", {31'b0, imem_req}, 32'h0);
    cyc();
    imem_ack = 1'b0;
    chk("rel_req_rise", {31'b0, imem_req}, 32'h1);
    chk("rel_addr",     imem_addr, 32'h0);
    chk("late_ack_ign", {31'b0, BubbleF}, 32'h1);

    // Fetch 0x0: request first rises, ack one cycle later.
    cyc();
    chk("f0_wait_bub", {31'b0, BubbleF}, 32'h1);
    imem_ack = 1'b1; imem_rdata = 32'h1100_0000;
    cyc();
    imem_ack = 1'b0;
    chk("f0_instr", InstrF, 32'h1100_0000);
    chk("f0_pcf",   PCF, 32'h0);
    chk("f0_req",   {31'b0, imem_req}, 32'h0);
    chk("f0_bub",   {31'b0, BubbleF}, 32'h0);

    // Consume; 0x4 is acked in the same cycle it is requested -> valid every 2 cycles.
    cyc();
    chk("f4_pcf",  PCF, 32'h4);
    chk("f4_addr", imem_addr, 32'h4);
    chk("f4_bub",  {31'b0, BubbleF}, 32'h1);
    imem_ack = 1'b1; imem_rdata = 32'h1100_0004;
    cyc();
    imem_ack = 1'b0;
    chk("f4_instr", InstrF, 32'h1100_0004);

    // Stall in HOLD for 3 cycles, with a redirect present that must be ignored.
    StallF = 1'b1; PCSrcD = 1'b1; PCBranchD = 32'h80;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_instr", InstrF, 32'h1100_0004);
      chk("stall_pcf",   PCF, 32'h4);
      chk("stall_req",   {31'b0, imem_req}, 32'h0);
    end
    StallF = 1'b0; PCSrcD = 1'b0;
    cyc();
    chk("unstall_pcf",  PCF, 32'h8);
    chk("unstall_addr", imem_addr, 32'h8);

    // Branch to 0x40 while 0x8 is outstanding -> DROP, late ack discarded.
    PCSrcD = 1'b1; PCBranchD = 32'h40;
    cyc();
    PCSrcD = 1'b0;
    chk("drop_pcf",  PCF, 32'h40);
    chk("drop_addr", imem_addr, 32'h8);
    chk("drop_req",  {31'b0, imem_req}, 32'h1);
    imem_ack = 1'b1; imem_rdata = 32'h1100_0008;
    cyc();
    imem_ack = 1'b0;
    chk("drop_next_addr", imem_addr, 32'h40);
    chk("drop_bub",       {31'b0, BubbleF}, 32'h1);
    chk("drop_instr",     InstrF, 32'h0);
    cyc();
    chk("f40_wait_bub", {31'b0, BubbleF}, 32'h1);
    imem_ack = 1'b1; imem_rdata = 32'h1100_0040;
    cyc();
    imem_ack = 1'b0;
    chk("f40_instr", InstrF, 32'h1100_0040);
    chk("f40_pcf",   PCF, 32'h40);

    // Jump and branch together from HOLD: jump wins, low bits cleared.
    PCSrcD = 1'b1; PCBranchD = 32'h100; JumpD = 1'b1; PCJumpD = 32'h203;
    cyc();
    PCSrcD = 1'b0; JumpD = 1'b0;
    chk("jprio_addr", imem_addr, 32'h200);
    chk("jprio_pcf",  PCF, 32'h200);

    // Redirect coincident with ack in REQ: data dropped, reissue with no DROP cycle.
    JumpD = 1'b1; PCJumpD = 32'h300;
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_0200;
    cyc();
    JumpD = 1'b0;
    chk("coinc_addr", imem_addr, 32'h300);
    chk("coinc_pcf",  PCF, 32'h300);
    chk("coinc_bub",  {31'b0, BubbleF}, 32'h1);
    imem_rdata = 32'h1100_0300;
    cyc();
    imem_ack = 1'b0;
    chk("f300_instr", InstrF, 32'h1100_0300);

    // PC wrap: fetch 0xFFFFFFFC, consume, next fetch is 0x0.
    PCSrcD = 1'b1; PCBranchD = 32'hFFFF_FFFC;
    cyc();
    PCSrcD = 1'b0;
    chk("wrap_pcf", PCF, 32'hFFFF_FFFC);
    chk("wrap_pc4", PCPlus4F, 32'h0);
    imem_ack = 1'b1; imem_rdata = 32'h1100_FFFC;
    cyc();
    imem_ack = 1'b0;
    chk("wrap_instr", InstrF, 32'h1100_FFFC);
    cyc();
    chk("wrap_next_addr", imem_addr, 32'h0);
    chk("wrap_next_pcf",  PCF, 32'h0);

    // Asynchronous reset mid-transaction, between clock edges.
    PCSrcD = 1'b1; PCBranchD = 32'h500;
    cyc();
    PCSrcD = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pcf",  PCF, 32'h0);
    chk("arst_addr", imem_addr, 32'h0);
    chk("arst_req",  {31'b0, imem_req}, 32'h0);
    chk("arst_bub",  {31'b0, BubbleF}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
